// File: rtl/sdram_xfer_sched.sv
// Block-ring scheduler for the SDRAM write/read master control ports.
// Optional per-transfer watchdog: define SDRAM_XFER_TIMEOUT_EN.
module sdram_xfer_sched #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned BLOCK_BYTES    = 2048,
  parameter int unsigned NUM_BLOCKS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic                          wr_req,
  input  logic                          rd_req,
  output logic                          wr_ctl_fixed_location,
  output logic [31:0]                   wr_ctl_write_base,
  output logic [31:0]                   wr_ctl_write_length,
  output logic                          wr_ctl_go,
  input  logic                          wr_ctl_done,
  output logic                          rd_ctl_fixed_location,
  output logic [31:0]                   rd_ctl_read_base,
  output logic [31:0]                   rd_ctl_read_length,
  output logic                          rd_ctl_go,
  input  logic                          rd_ctl_done,
  output logic                          wr_block_done,
  output logic                          rd_block_done,
  output logic                          busy,
  output logic [$clog2(NUM_BLOCKS):0]   level,
  output logic                          xfer_timeout
);

  localparam int unsigned PtrW   = $clog2(NUM_BLOCKS);
  localparam int unsigned LevelW = PtrW + 1;
  localparam logic [LevelW-1:0] LevelFull = LevelW'(NUM_BLOCKS);

  typedef enum logic [2:0] {
    StIdle,
    StWrGo,
    StWrStart,
    StWrEnd,
    StRdGo,
    StRdStart,
    StRdEnd
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]   level_q, level_d;
  logic                last_wr_q, last_wr_d;
  logic [31:0]         wr_base_q, wr_base_d;
  logic [31:0]         rd_base_q, rd_base_d;
  logic                wr_done_q, wr_done_d;
  logic                rd_done_q, rd_done_d;

  logic                timeout_hit;
  logic                timeout_flag;
  logic                wr_ok, rd_ok;
  logic [31:0]         wr_addr, rd_addr;

  // Block addresses wrap modulo 2^32 by construction of the 32-bit sum.
  assign wr_addr = BASE_ADDR + (32'(wr_ptr_q) * BLOCK_BYTES);
  assign rd_addr = BASE_ADDR + (32'(rd_ptr_q) * BLOCK_BYTES);

  assign wr_ok = enable & wr_req & (level_q != LevelFull) & ~timeout_flag;
  assign rd_ok = enable & rd_req & (level_q != '0) & ~timeout_flag;

`ifdef SDRAM_XFER_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StWrGo, StRdGo: wdog_d = '0;
      StWrStart, StWrEnd, StRdStart, StRdEnd: begin
        wdog_d = wdog_q + 32'd1;
        if (wdog_d >= TIMEOUT_CYCLES) begin
          timeout_hit = 1'b1;
          timeout_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
  // Keeps the watchdog limit referenced in builds without the watchdog.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_ref
  end
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    last_wr_d = last_wr_q;
    wr_base_d = wr_base_q;
    rd_base_d = rd_base_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, serve whichever side was not served last.
        if (wr_ok && (!rd_ok || !last_wr_q)) begin
          state_d   = StWrGo;
          wr_base_d = wr_addr;
        end else if (rd_ok) begin
          state_d   = StRdGo;
          rd_base_d = rd_addr;
        end
      end
      StWrGo: state_d = StWrStart;
      StWrStart: begin
        if (!wr_ctl_done) state_d = StWrEnd;
      end
      StWrEnd: begin
        if (wr_ctl_done && !timeout_hit) begin
          state_d   = StIdle;
          wr_ptr_d  = wr_ptr_q + PtrW'(1);
          level_d   = level_q + LevelW'(1);
          wr_done_d = 1'b1;
          last_wr_d = 1'b1;
        end
      end
      StRdGo: state_d = StRdStart;
      StRdStart: begin
        if (!rd_ctl_done) state_d = StRdEnd;
      end
      StRdEnd: begin
        if (rd_ctl_done && !timeout_hit) begin
          state_d   = StIdle;
          rd_ptr_d  = rd_ptr_q + PtrW'(1);
          level_d   = level_q - LevelW'(1);
          rd_done_d = 1'b1;
          last_wr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) state_d = StIdle;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      last_wr_q <= 1'b0;
      wr_base_q <= BASE_ADDR;
      rd_base_q <= BASE_ADDR;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      last_wr_q <= last_wr_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign wr_ctl_fixed_location = 1'b0;
  assign rd_ctl_fixed_location = 1'b0;
  assign wr_ctl_write_length   = 32'(BLOCK_BYTES);
  assign rd_ctl_read_length    = 32'(BLOCK_BYTES);
  assign wr_ctl_write_base     = wr_base_q;
  assign rd_ctl_read_base      = rd_base_q;
  assign wr_ctl_go             = (state_q == StWrGo);
  assign rd_ctl_go             = (state_q == StRdGo);
  assign wr_block_done         = wr_done_q;
  assign rd_block_done         = rd_done_q;
  assign busy                  = (state_q != StIdle);
  assign level                 = level_q;
  assign xfer_timeout          = timeout_flag;

endmodule

// File: tb/tb_sdram_xfer_sched.sv
// Scoreboard bench for sdram_xfer_sched with behavioural write/read master models.
module tb_sdram_xfer_sched;

  localparam logic [31:0] Base = 32'h0000_1000;
  localparam int unsigned Bb   = 2048;
  localparam int unsigned Nb   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic        wr_fixed, rd_fixed, wr_go, rd_go, wr_done, rd_done;
  logic [31:0] wr_base, wr_len, rd_base, rd_len;
  logic        wr_bd, rd_bd, busy, xfer_timeout;
  logic [3:0]  level;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  bit          order_q[$];
  int          wr_go_count = 0, rd_go_count = 0;
  bit          prev_wr_go = 0, prev_rd_go = 0;
  int          wr_t = 0, rd_t = 0;
  bit          wr_hang = 0;

  always #5 clk = ~clk;

  sdram_xfer_sched #(
    .BASE_ADDR(Base),
    .BLOCK_BYTES(Bb),
    .NUM_BLOCKS(Nb),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .enable(enable),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .wr_ctl_fixed_location(wr_fixed),
    .wr_ctl_write_base(wr_base),
    .wr_ctl_write_length(wr_len),
    .wr_ctl_go(wr_go),
    .wr_ctl_done(wr_done),
    .rd_ctl_fixed_location(rd_fixed),
    .rd_ctl_read_base(rd_base),
    .rd_ctl_read_length(rd_len),
    .rd_ctl_go(rd_go),
    .rd_ctl_done(rd_done),
    .wr_block_done(wr_bd),
    .rd_block_done(rd_bd),
    .busy(busy),
    .level(level),
    .xfer_timeout(xfer_timeout)
  );

  // Master models: done drops 2 cycles after go and rises 20 cycles after that.
  always @(posedge clk) begin
    if (wr_go && !wr_hang) wr_t <= 1;
    else if (wr_t != 0) wr_t <= (wr_t == 22) ? 0 : wr_t + 1;
    if (rd_go) rd_t <= 1;
    else if (rd_t != 0) rd_t <= (rd_t == 22) ? 0 : rd_t + 1;
  end
  assign wr_done = !(wr_t >= 2 && wr_t <= 21);
  assign rd_done = !(rd_t >= 2 && rd_t <= 21);

  // Scoreboard: every go pulse pops the expected base address for that side.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr_go = 0;
      prev_rd_go = 0;
    end else begin
      if (wr_go) begin
        wr_go_count++;
        order_q.push_back(1'b1);
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_go_unexpected base=%h expected no go", wr_base);
        end else begin
          logic [31:0] e;
          e = exp_wr_q.pop_front();
          if (wr_base !== e || wr_len !== 32'(Bb) || wr_fixed !== 1'b0 || prev_wr_go) begin
            failures++;
            $display("FAIL wr_go_cmd base=%h len=%0d fix=%b got, base=%h len=%0d fix=0 single-cycle",
                     wr_base, wr_len, wr_fixed, e, Bb);
          end
        end
      end
      if (rd_go) begin
        rd_go_count++;
        order_q.push_back(1'b0);
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_go_unexpected base=%h expected no go", rd_base);
        end else begin
          logic [31:0] e;
          e = exp_rd_q.pop_front();
          if (rd_base !== e || rd_len !== 32'(Bb) || rd_fixed !== 1'b0 || prev_rd_go) begin
            failures++;
            $display("FAIL rd_go_cmd base=%h len=%0d fix=%b got, base=%h len=%0d fix=0 single-cycle",
                     rd_base, rd_len, rd_fixed, e, Bb);
          end
        end
      end
      prev_wr_go = wr_go;
      prev_rd_go = rd_go;
    end
  end

  task automatic test_reset();
    rst_n = 0; enable = 0; wr_req = 0; rd_req = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wr_go, rd_go, wr_bd, rd_bd, xfer_timeout, wr_fixed, rd_fixed} !== 8'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=00000000",
               {busy, wr_go, rd_go, wr_bd, rd_bd, xfer_timeout, wr_fixed, rd_fixed});
    end
    checks++;
    if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d expected=0", level); end
    checks++;
    if (wr_base !== Base || rd_base !== Base) begin
      failures++;
      $display("FAIL reset_base got=%h/%h expected=%h", wr_base, rd_base, Base);
    end
    checks++;
    if (wr_len !== 32'(Bb) || rd_len !== 32'(Bb)) begin
      failures++;
      $display("FAIL reset_length got=%0d/%0d expected=%0d", wr_len, rd_len, Bb);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int n;
    exp_wr_q.push_back(Base);
    enable = 1; wr_req = 1;
    n = 0;
    while (!wr_go && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!wr_go) begin failures++; $display("FAIL single_go got=no go expected=go within 10"); end
    wr_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_bd && n < 40);
    checks++;
    if (n !== 23) begin failures++; $display("FAIL single_latency got=%0d expected=23", n); end
    checks++;
    if (level !== 4'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_level got=%0d busy=%b expected=1 busy=0", level, busy);
    end
    @(negedge clk);
    checks++;
    if (wr_bd !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=1 expected=0"); end
  endtask

  task automatic test_wrap();
    int n;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    wr_go_count = 0; rd_go_count = 0;
    for (int i = 0; i < int'(Nb); i++) exp_wr_q.push_back(Base + 32'(i) * 32'h800);
    wr_req = 1;
    n = 0;
    while (level !== 4'd8 && n < 400) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    checks++;
    if (level !== 4'd8 || wr_go_count !== 8 || exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_full got level=%0d writes=%0d expected level=8 writes=8",
               level, wr_go_count);
    end
    wr_req = 0;
    for (int i = 0; i < int'(Nb); i++) exp_rd_q.push_back(Base + 32'(i) * 32'h800);
    rd_req = 1;
    n = 0;
    while (level !== 4'd0 && n < 400) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    checks++;
    if (level !== 4'd0 || rd_go_count !== 8 || exp_rd_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_empty got level=%0d reads=%0d expected level=0 reads=8",
               level, rd_go_count);
    end
    rd_req = 0;
  endtask

  task automatic test_tie();
    int n;
    logic [3:0] lmin, lmax;
    logic [5:0] order;
    for (int i = 0; i < 3; i++) exp_wr_q.push_back(Base + 32'(i) * 32'h800);
    wr_req = 1;
    n = 0;
    while (level !== 4'd3 && n < 200) begin @(negedge clk); n++; end
    wr_req = 0;
    exp_rd_q.push_back(Base);
    rd_req = 1;
    n = 0;
    while (level !== 4'd2 && n < 100) begin @(negedge clk); n++; end
    rd_req = 0;
    order_q.delete();
    for (int i = 3; i < 6; i++) exp_wr_q.push_back(Base + 32'(i) * 32'h800);
    for (int i = 1; i < 4; i++) exp_rd_q.push_back(Base + 32'(i) * 32'h800);
    lmin = level; lmax = level;
    wr_req = 1; rd_req = 1;
    n = 0;
    while (order_q.size() < 6 && n < 300) begin
      @(negedge clk); n++;
      if (level < lmin) lmin = level;
      if (level > lmax) lmax = level;
    end
    wr_req = 0; rd_req = 0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk); n++;
      if (level < lmin) lmin = level;
      if (level > lmax) lmax = level;
    end
    @(negedge clk);
    order = 6'b0;
    for (int i = 0; i < 6 && i < order_q.size(); i++) order[5-i] = order_q[i];
    checks++;
    if (order_q.size() != 6 || order !== 6'b101010) begin
      failures++;
      $display("FAIL tie_order got=%b n=%0d expected=101010 (1=W)", order, order_q.size());
    end
    checks++;
    if (lmin !== 4'd2 || lmax !== 4'd3 || level !== 4'd2) begin
      failures++;
      $display("FAIL tie_level got min=%0d max=%0d end=%0d expected 2/3/2", lmin, lmax, level);
    end
  endtask

  task automatic test_enable_guard();
    int wc, rc;
    bit busy_seen;
    wc = wr_go_count; rc = rd_go_count; busy_seen = 0;
    enable = 0; wr_req = 1; rd_req = 1;
    repeat (50) begin @(negedge clk); busy_seen |= busy; end
    checks++;
    if (wr_go_count !== wc || rd_go_count !== rc || busy_seen) begin
      failures++;
      $display("FAIL enable_guard got gos=%0d busy=%b expected gos=0 busy=0",
               (wr_go_count - wc) + (rd_go_count - rc), busy_seen);
    end
    wr_req = 0; rd_req = 0; enable = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    exp_wr_q.push_back(Base + 32'd6 * 32'h800);
    wr_req = 1;
    n = 0;
    while (!wr_go && n < 10) begin @(negedge clk); n++; end
    wr_req = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wr_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_setup got busy=%b done=%b expected busy=1 done=0", busy, wr_done);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || level !== 4'd0 || wr_go !== 1'b0 || wr_base !== Base || wr_bd !== 1'b0)
    begin
      failures++;
      $display("FAIL midreset_async got busy=%b level=%0d base=%h expected 0/0/%h",
               busy, level, wr_base, Base);
    end
    repeat (30) @(negedge clk);
    rst_n = 1;
    exp_wr_q.push_back(Base);
    wr_req = 1;
    n = 0;
    while (!wr_bd && n < 50) begin
      @(negedge clk); n++;
      if (wr_go) wr_req = 0;
    end
    wr_req = 0;
    checks++;
    if (!wr_bd || level !== 4'd1) begin
      failures++;
      $display("FAIL midreset_after got done=%b level=%0d expected done=1 level=1", wr_bd, level);
    end
    @(negedge clk);
  endtask

`ifdef SDRAM_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int n, wc, rc;
    wr_hang = 1;
    exp_wr_q.push_back(Base + 32'h800);
    wr_req = 1;
    n = 0;
    while (!wr_go && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!xfer_timeout && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== 101) begin failures++; $display("FAIL timeout_latency got=%0d expected=101", n); end
    checks++;
    if (level !== 4'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state got level=%0d busy=%b expected 1/0", level, busy);
    end
    wc = wr_go_count; rc = rd_go_count;
    rd_req = 1;
    repeat (60) @(negedge clk);
    checks++;
    if (wr_go_count !== wc || rd_go_count !== rc || xfer_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_block got gos=%0d flag=%b expected gos=0 flag=1",
               (wr_go_count - wc) + (rd_go_count - rc), xfer_timeout);
    end
    wr_req = 0; rd_req = 0; wr_hang = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_wrap();
    test_tie();
    test_enable_guard();
    test_reset_mid();
`ifdef SDRAM_XFER_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (xfer_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_tied got=%b expected=0", xfer_timeout);
    end
`endif
    checks++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got wr=%0d rd=%0d pending expected 0/0",
               exp_wr_q.size(), exp_rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=time limit expected=bench completion");
    $fatal(1, "bench time limit");
  end

endmodule
